// File: rtl/fifo_mmio_if.sv
// MMIO host bus for fifo_mmio_ctrl: request strobes/address/data and the
// registered read-response channel.
interface fifo_mmio_if;
  logic        mmio_wr_valid;
  logic        mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wdata;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;

  modport master (
    output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
    input  rsp_valid, rsp_tid, rsp_data
  );

  modport slave (
    input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
    output rsp_valid, rsp_tid, rsp_data
  );
endinterface

// File: rtl/fifo_mmio_ctrl.sv
// MMIO front end for an external shift-register FIFO. Host pushes words,
// reads the oldest entry once the FIFO is full, reads status, and can
// drain the FIFO by shifting DEPTH zero words through it.
// Optional feature: define FIFO_MMIO_CTRL_PERF_EN to add a 32-bit
// accepted-push counter readable at 0x0026.
module fifo_mmio_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_mmio_if.slave       bus,
  input  logic [WIDTH-1:0] fifo_q,
  output logic             fifo_en,
  output logic [WIDTH-1:0] fifo_d,
  output logic [7:0]       count,
  output logic             primed,
  output logic             dropped
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    PRIMED = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [15:0] ADDR_DATA   = 16'h0020;
  localparam logic [15:0] ADDR_STATUS = 16'h0022;
  localparam logic [15:0] ADDR_CMD    = 16'h0024;
  localparam logic [15:0] ADDR_PERF   = 16'h0026;
  localparam logic [7:0]  DEPTH_FULL  = 8'(DEPTH);
  localparam logic [7:0]  DEPTH_LAST  = 8'(DEPTH - 1);

  state_t           state, state_nx;
  logic [7:0]       count_nx;
  logic [7:0]       drain_cnt, drain_cnt_nx;
  logic             dropped_nx;
  logic             fifo_en_nx;
  logic [WIDTH-1:0] fifo_d_nx;
  logic             push_wr;
  logic             cmd_wr;
  logic [63:0]      q_ext;
  logic [63:0]      rd_data;
`ifdef FIFO_MMIO_CTRL_PERF_EN
  logic [31:0]      push_cnt;
`endif

  assign push_wr = bus.mmio_wr_valid && (bus.mmio_addr == ADDR_DATA);
  assign cmd_wr  = bus.mmio_wr_valid && (bus.mmio_addr == ADDR_CMD);
  assign q_ext   = 64'(fifo_q);
  assign primed  = (count == DEPTH_FULL);

  // Next-state logic: pushes, drain sequencing and the sticky drop flag.
  always_comb begin
    state_nx     = state;
    count_nx     = count;
    drain_cnt_nx = drain_cnt;
    dropped_nx   = dropped;
    fifo_en_nx   = 1'b0;
    fifo_d_nx    = fifo_d;
    if (cmd_wr && bus.mmio_wdata[1]) begin
      dropped_nx = 1'b0;
    end
    if (state == DRAIN) begin
      if (push_wr) begin
        dropped_nx = 1'b1;
      end
      if (drain_cnt == DEPTH_LAST) begin
        state_nx     = IDLE;
        count_nx     = '0;
        drain_cnt_nx = '0;
      end else begin
        drain_cnt_nx = drain_cnt + 8'd1;
        fifo_en_nx   = 1'b1;
        fifo_d_nx    = '0;
      end
    end else if (push_wr) begin
      fifo_en_nx = 1'b1;
      fifo_d_nx  = WIDTH'(bus.mmio_wdata);
      if (count != DEPTH_FULL) begin
        count_nx = count + 8'd1;
      end
      state_nx = (count_nx == DEPTH_FULL) ? PRIMED : FILL;
    end else if (cmd_wr && bus.mmio_wdata[0]) begin
      state_nx     = DRAIN;
      drain_cnt_nx = '0;
      fifo_en_nx   = 1'b1;
      fifo_d_nx    = '0;
    end
  end

  // Control state and FIFO drive registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      drain_cnt <= '0;
      dropped   <= 1'b0;
      fifo_en   <= 1'b0;
      fifo_d    <= '0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      drain_cnt <= drain_cnt_nx;
      dropped   <= dropped_nx;
      fifo_en   <= fifo_en_nx;
      fifo_d    <= fifo_d_nx;
    end
  end

`ifdef FIFO_MMIO_CTRL_PERF_EN
  // Accepted-push counter, cleared together with the drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_cnt <= '0;
    end else if (cmd_wr && bus.mmio_wdata[1]) begin
      push_cnt <= '0;
    end else if (push_wr && (state != DRAIN)) begin
      push_cnt <= push_cnt + 32'd1;
    end
  end
`endif

  // Read decode from the pre-write register state.
  always_comb begin
    rd_data = '0;
    case (bus.mmio_addr)
      ADDR_DATA:   rd_data = (state == PRIMED) ? q_ext : 64'd0;
      ADDR_STATUS: rd_data = {53'd0, dropped, state, count};
`ifdef FIFO_MMIO_CTRL_PERF_EN
      ADDR_PERF:   rd_data = {32'd0, push_cnt};
`endif
      default:     rd_data = '0;
    endcase
  end

  // One-cycle registered read response; tid/data hold until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_tid   <= '0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= bus.mmio_rd_valid;
      if (bus.mmio_rd_valid) begin
        bus.rsp_tid  <= bus.mmio_tid;
        bus.rsp_data <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_fifo_mmio_ctrl.sv
// Scoreboard bench for fifo_mmio_ctrl: expected fifo shifts and read
// responses are queued with their due cycle when stimulus is driven and
// checked by a monitor every cycle.
module tb_fifo_mmio_ctrl;
  localparam int DEPTH = 8;
  localparam int WIDTH = 64;

  typedef struct {
    int unsigned cyc;
    logic [63:0] data;
  } en_exp_t;

  typedef struct {
    int unsigned cyc;
    logic [8:0]  tid;
    logic [63:0] data;
  } rsp_exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] fifo_q;
  logic             fifo_en;
  logic [WIDTH-1:0] fifo_d;
  logic [7:0]       count;
  logic             primed;
  logic             dropped;
  logic [WIDTH-1:0] fifo_mem [DEPTH] = '{default: '0};

  en_exp_t     en_q[$];
  rsp_exp_t    rsp_q[$];
  en_exp_t     mon_e;
  rsp_exp_t    mon_r;
  int unsigned cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  int          m_count;
  bit          m_dropped;
  bit          m_draining;
  int unsigned m_drain_end;
  logic [31:0] m_perf;
  logic [63:0] m_fifo[$];

  fifo_mmio_if bus();

  fifo_mmio_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .fifo_q  (fifo_q),
    .fifo_en (fifo_en),
    .fifo_d  (fifo_d),
    .count   (count),
    .primed  (primed),
    .dropped (dropped)
  );

  always #5 clk = ~clk;

  // External shift-register FIFO: index 0 newest, DEPTH-1 oldest.
  always @(posedge clk) begin
    if (fifo_en) begin
      for (int i = DEPTH - 1; i > 0; i--) fifo_mem[i] <= fifo_mem[i-1];
      fifo_mem[0] <= fifo_d;
    end
  end
  assign fifo_q = fifo_mem[DEPTH-1];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int model_state();
    if (m_draining) return 3;
    if (m_count == 0) return 0;
    if (m_count == DEPTH) return 2;
    return 1;
  endfunction

  // Monitor: every cycle compare DUT outputs against due expectations.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (en_q.size() > 0 && en_q[0].cyc == cyc) begin
      mon_e = en_q.pop_front();
      checkOutput("fifoEn", {63'd0, fifo_en}, 64'd1);
      checkOutput("fifoD", fifo_d, mon_e.data);
    end else begin
      checkOutput("fifoEnIdle", {63'd0, fifo_en}, 64'd0);
    end
    if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
      mon_r = rsp_q.pop_front();
      checkOutput("rspValid", {63'd0, bus.rsp_valid}, 64'd1);
      checkOutput("rspTid", {55'd0, bus.rsp_tid}, {55'd0, mon_r.tid});
      checkOutput("rspData", bus.rsp_data, mon_r.data);
    end else begin
      checkOutput("rspValidIdle", {63'd0, bus.rsp_valid}, 64'd0);
    end
  end

  task automatic applyStimulus(input bit wr, input bit rd, input logic [15:0] addr,
                               input logic [8:0] tid, input logic [63:0] wdata);
    int unsigned q;
    logic [63:0] rd_exp;
    en_exp_t     e;
    rsp_exp_t    r;
    @(negedge clk);
    bus.mmio_wr_valid = wr;
    bus.mmio_rd_valid = rd;
    bus.mmio_addr     = addr;
    bus.mmio_tid      = tid;
    bus.mmio_wdata    = wdata;
    q = cyc + 1;
    if (m_draining && q > m_drain_end) begin
      m_draining = 1'b0;
      m_count    = 0;
    end
    if (rd) begin
      rd_exp = 64'd0;
      case (addr)
        16'h0020: if (model_state() == 2) rd_exp = m_fifo[0];
        16'h0022: rd_exp = {53'd0, m_dropped, 2'(model_state()), 8'(m_count)};
`ifdef FIFO_MMIO_CTRL_PERF_EN
        16'h0026: rd_exp = {32'd0, m_perf};
`endif
        default:  rd_exp = 64'd0;
      endcase
      r.cyc  = q;
      r.tid  = tid;
      r.data = rd_exp;
      rsp_q.push_back(r);
    end
    if (wr && addr == 16'h0020) begin
      if (m_draining) begin
        m_dropped = 1'b1;
      end else begin
        e.cyc  = q;
        e.data = wdata;
        en_q.push_back(e);
        m_fifo.push_back(wdata);
        if (m_fifo.size() > DEPTH) void'(m_fifo.pop_front());
        if (m_count < DEPTH) m_count++;
        m_perf++;
      end
    end
    if (wr && addr == 16'h0024) begin
      if (wdata[1]) begin
        m_dropped = 1'b0;
        m_perf    = '0;
      end
      if (wdata[0] && !m_draining) begin
        m_draining  = 1'b1;
        m_drain_end = q + DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
          e.cyc  = q + i;
          e.data = 64'd0;
          en_q.push_back(e);
          m_fifo.push_back(64'd0);
          if (m_fifo.size() > DEPTH) void'(m_fifo.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    bus.mmio_wr_valid = 1'b0;
    bus.mmio_rd_valid = 1'b0;
  endtask

  task automatic mmio_push(input logic [63:0] data);
    applyStimulus(1'b1, 1'b0, 16'h0020, 9'd0, data);
  endtask

  task automatic mmio_read(input logic [15:0] addr, input logic [8:0] tid);
    applyStimulus(1'b0, 1'b1, addr, tid, 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    en_q.delete();
    rsp_q.delete();
    m_count    = 0;
    m_dropped  = 1'b0;
    m_draining = 1'b0;
    m_perf     = '0;
  endtask

  initial begin
    bus.mmio_wr_valid = 1'b0;
    bus.mmio_rd_valid = 1'b0;
    bus.mmio_addr     = '0;
    bus.mmio_tid      = '0;
    bus.mmio_wdata    = '0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(1);

    checkOutput("rstFifoEn", {63'd0, fifo_en}, 64'd0);
    checkOutput("rstFifoD", fifo_d, 64'd0);
    checkOutput("rstCount", {56'd0, count}, 64'd0);
    checkOutput("rstPrimed", {63'd0, primed}, 64'd0);
    checkOutput("rstDropped", {63'd0, dropped}, 64'd0);
    checkOutput("rstRspValid", {63'd0, bus.rsp_valid}, 64'd0);
    checkOutput("rstRspTid", {55'd0, bus.rsp_tid}, 64'd0);
    checkOutput("rstRspData", bus.rsp_data, 64'd0);
    mmio_read(16'h0022, 9'h000);

    for (int i = 1; i <= 3; i++) mmio_push(64'(i));
    checkOutput("count3", {56'd0, count}, 64'd3);
    mmio_read(16'h0022, 9'h1A5);
    for (int i = 4; i <= 7; i++) mmio_push(64'(i));
    applyStimulus(1'b1, 1'b1, 16'h0020, 9'h033, 64'd8);
    idle_cycles(2);
    checkOutput("count8", {56'd0, count}, 64'd8);
    checkOutput("primed", {63'd0, primed}, 64'd1);
    mmio_read(16'h0020, 9'h001);

    mmio_push(64'h9);
    checkOutput("countSat", {56'd0, count}, 64'd8);
    idle_cycles(2);
    mmio_read(16'h0020, 9'h002);

    applyStimulus(1'b1, 1'b0, 16'h0024, 9'd0, 64'h1);
    mmio_push(64'hAA);
    mmio_read(16'h0030, 9'h00F);
    applyStimulus(1'b1, 1'b0, 16'h0024, 9'd0, 64'h1);
    idle_cycles(10);
    checkOutput("countDrained", {56'd0, count}, 64'd0);
    checkOutput("droppedSet", {63'd0, dropped}, 64'd1);
    mmio_read(16'h0022, 9'h010);

    applyStimulus(1'b1, 1'b0, 16'h0024, 9'd0, 64'h2);
    checkOutput("droppedClr", {63'd0, dropped}, 64'd0);
    mmio_read(16'h0030, 9'h011);
    mmio_read(16'h0024, 9'h012);

    for (int i = 0; i < 10; i++) mmio_push(64'h100 + 64'(i));
    idle_cycles(2);
    mmio_read(16'h0026, 9'h0AB);
    mmio_read(16'h0020, 9'h0AC);
    mmio_read(16'h0022, 9'h0AD);

    applyStimulus(1'b1, 1'b0, 16'h0024, 9'd0, 64'h3);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstAbortEn", {63'd0, fifo_en}, 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);
    checkOutput("abortCount", {56'd0, count}, 64'd0);
    mmio_read(16'h0022, 9'h020);
    mmio_push(64'h55);
    checkOutput("countAfterAbort", {56'd0, count}, 64'd1);
    mmio_read(16'h0022, 9'h021);
    mmio_read(16'h0026, 9'h022);
    idle_cycles(3);

    checkOutput("enQueueEmpty", 64'(en_q.size()), 64'd0);
    checkOutput("rspQueueEmpty", 64'(rsp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fifo_mmio_ctrl.md
FIFO_MMIO_CTRL -- requirements
Module: fifo_mmio_ctrl

Interface
REQ-001: Parameter DEPTH, default 8, shift-register FIFO depth in entries (2..255).
REQ-002: Parameter WIDTH, default 64, FIFO data width in bits.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  reset, asynchronous and active-low.
REQ-005: mmio_wr_valid  input  1  host MMIO write strobe, one cycle per write.
REQ-006: mmio_rd_valid  input  1  host MMIO read strobe, one cycle per read.
REQ-007: mmio_addr  input  16  MMIO word address for the current strobe.
REQ-008: mmio_tid  input  9  read transaction ID.
REQ-009: mmio_wdata  input  64  MMIO write data.
REQ-010: fifo_q  input  WIDTH  FIFO output word (oldest entry).
REQ-011: fifo_en  output  1  FIFO shift enable, one cycle per shift.
REQ-012: fifo_d  output  WIDTH  word shifted into the FIFO when fifo_en is high.
REQ-013: rsp_valid  output  1  MMIO read response strobe.
REQ-014: rsp_tid  output  9  echoed mmio_tid of the answered read.
REQ-015: rsp_data  output  64  read response data.
REQ-016: count  output  8  entries written since last drain, saturating at DEPTH.
REQ-017: primed  output  1  high when count == DEPTH (fifo_q holds valid data).
REQ-018: dropped  output  1  sticky flag: a push was discarded.

Function
REQ-019: Register map: 0x0020 W push / R fifo_q; 0x0022 R status {dropped[10], state[9:8], count[7:0]}; 0x0024 W command (bit0 drain, bit1 clear dropped); unmapped reads return 0, unmapped writes ignored.
REQ-020: States IDLE (count 0), FILL (0 < count < DEPTH), PRIMED (count == DEPTH), DRAIN; encoding 0,1,2,3.
REQ-021: Push in IDLE/FILL/PRIMED: fifo_en high and fifo_d = mmio_wdata[WIDTH-1:0] for exactly the cycle after the write strobe (1-cycle latency).
REQ-022: Push increments count; count saturates at DEPTH; IDLE->FILL on first push, FILL->PRIMED when count reaches DEPTH; pushes in PRIMED shift out oldest entry, count unchanged.
REQ-023: Drain command in any non-DRAIN state enters DRAIN next cycle; DRAIN issues exactly DEPTH consecutive fifo_en cycles with fifo_d = 0, then IDLE with count 0.
REQ-024: Push received in DRAIN is discarded (no fifo_en) and sets dropped.
REQ-025: Drain command received in DRAIN is ignored; drain sequence not restarted.
REQ-026: Clear-dropped clears dropped next cycle; if the same write also requests drain, both take effect; a drop in the same cycle as clear leaves dropped set.
REQ-027: Read response: rsp_valid high exactly one cycle after mmio_rd_valid, rsp_tid = mmio_tid, rsp_data per map; reads served in every state, including DRAIN.
REQ-028: Read of 0x0020 while not PRIMED returns 0; when PRIMED returns fifo_q zero-extended to 64 bits.
REQ-029: Simultaneous mmio_wr_valid and mmio_rd_valid both serviced in the same cycle; read returns pre-write state.
REQ-030: rsp_valid deasserts the cycle after a response unless another read arrived.

Reset
REQ-031: On rst_n low, asynchronously: state IDLE, count 0, dropped 0, fifo_en 0, fifo_d 0, rsp_valid 0, rsp_tid 0, rsp_data 0.
REQ-032: Reset mid-DRAIN aborts the sequence; no further fifo_en until a new push; FIFO contents are not cleared by this block.

Configuration
REQ-033: Macro FIFO_MMIO_CTRL_PERF_EN defined: 32-bit push counter (accepted pushes, wraps at 2^32, reset 0, cleared by clear-dropped) readable at 0x0026 zero-extended.
REQ-034: Macro undefined: no counter logic; read of 0x0026 returns 0.

Verification
REQ-035: DEPTH=8; push 0x1..0x8 -> fifo_en 8 pulses each 1 cycle after write, count 8, primed 1, read 0x0020 returns 0x1.
REQ-036: 3 pushes then read 0x0022 tid 0x1A5 -> next cycle rsp_valid, rsp_tid 0x1A5, rsp_data 0x0000_0000_0000_0103.
REQ-037: Primed, write 0x0024=0x1 -> 8 consecutive fifo_en with fifo_d 0, then status 0x000; push during drain -> no fifo_en, dropped 1.
REQ-038: Dropped set, write 0x0024=0x2 -> dropped 0 next cycle; read 0x0030 -> rsp_data 0.
REQ-039: rst_n low during 4th drain cycle -> fifo_en low immediately, status 0 after release, next push gives count 1.
REQ-040: With FIFO_MMIO_CTRL_PERF_EN, 10 pushes then read 0x0026 -> 10; without macro -> 0.
